// File: rtl/matrix_scan_bcm_if.sv
// Scan bus between the matrix scan generator (master) and its consumers (slave):
// run/dim requests in, panel strobes, addresses and status out.
interface matrix_scan_bcm_if #(
    parameter int unsigned COLUMNS   = 64,
    parameter int unsigned ROWS      = 16,
    parameter int unsigned BITPLANES = 6,
    parameter int unsigned DIM_BITS  = 8
);
    localparam int unsigned COL_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                 enable;
    logic [DIM_BITS-1:0]  dim;
    logic [COL_W-1:0]     column_address;
    logic [ROW_W-1:0]     row_address;
    logic [ROW_W-1:0]     row_address_active;
    logic                 clk_pixel_load;
    logic                 clk_pixel;
    logic                 row_latch;
    logic                 output_enable;
    logic [BITPLANES-1:0] brightness_mask;
    logic                 frame_start;
    logic                 busy;

    modport master (
        input  enable, dim,
        output column_address, row_address, row_address_active, clk_pixel_load, clk_pixel,
               row_latch, output_enable, brightness_mask, frame_start, busy
    );

    modport slave (
        output enable, dim,
        input  column_address, row_address, row_address_active, clk_pixel_load, clk_pixel,
               row_latch, output_enable, brightness_mask, frame_start, busy
    );
endinterface

// File: rtl/matrix_scan_bcm.sv
// HUB75-style matrix scan generator with binary-coded modulation and global dimming.
// Each (row, plane) runs SHIFT (2 cycles/column), BLANK, LATCH, then a BASE_ON<<plane window.
module matrix_scan_bcm #(
    parameter int unsigned COLUMNS   = 64,
    parameter int unsigned ROWS      = 16,
    parameter int unsigned BITPLANES = 6,
    parameter int unsigned BASE_ON   = 4,
    parameter int unsigned DIM_BITS  = 8
) (
    input logic               clk_in,
    input logic               reset,
    matrix_scan_bcm_if.master bus
);
    localparam int unsigned COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PL_W   = (BITPLANES > 1) ? $clog2(BITPLANES) : 1;
    localparam int unsigned W_MAX  = BASE_ON << (BITPLANES - 1);
    localparam int unsigned CNT_W  = $clog2(W_MAX + 1);
    localparam int unsigned PROD_W = CNT_W + DIM_BITS + 1;

    typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

    state_e               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 phase_q, phase_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [ROW_W-1:0]     row_active_q, row_active_d;
    logic [PL_W-1:0]      plane_q, plane_d;
    logic [CNT_W-1:0]     disp_q, disp_d;
    logic [DIM_BITS-1:0]  dim_q, dim_d;
    logic [BITPLANES-1:0] mask_q, mask_d;

    logic [CNT_W-1:0]  window;
    logic [PROD_W-1:0] product;
    logic [CNT_W-1:0]  on_count;
    logic              pixel_load, pixel, latch, oe, fstart;

    // Full-width product so dim=max yields exactly the whole window.
    assign window   = CNT_W'(BASE_ON) << plane_q;
    assign product  = PROD_W'(window) * (PROD_W'(dim_q) + PROD_W'(1));
    assign on_count = CNT_W'(product >> DIM_BITS);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            col_q        <= '0;
            phase_q      <= 1'b0;
            row_q        <= '0;
            row_active_q <= '0;
            plane_q      <= '0;
            disp_q       <= '0;
            dim_q        <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            row_q        <= row_d;
            row_active_q <= row_active_d;
            plane_q      <= plane_d;
            disp_q       <= disp_d;
            dim_q        <= dim_d;
            mask_q       <= mask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        phase_d      = phase_q;
        row_d        = row_q;
        row_active_d = row_active_q;
        plane_d      = plane_q;
        disp_d       = disp_q;
        dim_d        = dim_q;
        mask_d       = mask_q;
        pixel_load   = 1'b0;
        pixel        = 1'b0;
        latch        = 1'b0;
        oe           = 1'b0;
        fstart       = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d = StShift;
                    row_d   = '0;
                    plane_d = '0;
                    col_d   = '0;
                    phase_d = 1'b0;
                end
            end
            StShift: begin
                if (!phase_q) begin
                    pixel_load = 1'b1;
                    phase_d    = 1'b1;
                    if (row_q == '0 && plane_q == '0 && col_q == '0) begin
                        fstart = 1'b1;
                        dim_d  = bus.dim;
                    end
                end else begin
                    pixel   = 1'b1;
                    phase_d = 1'b0;
                    if (col_q == COL_W'(COLUMNS - 1)) begin
                        col_d   = '0;
                        state_d = StBlank;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StBlank: state_d = StLatch;
            StLatch: begin
                latch        = 1'b1;
                row_active_d = row_q;
                mask_d       = BITPLANES'(1) << plane_q;
                disp_d       = '0;
                state_d      = StDisplay;
            end
            StDisplay: begin
                oe = (disp_q < on_count);
                if (disp_q == window - CNT_W'(1)) begin
                    disp_d = '0;
                    // Stopping holds row/plane; a restart always begins a fresh frame.
                    if (!bus.enable) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StShift;
                        if (plane_q == PL_W'(BITPLANES - 1)) begin
                            plane_d = '0;
                            row_d   = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                        end else begin
                            plane_d = plane_q + PL_W'(1);
                        end
                    end
                end else begin
                    disp_d = disp_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.column_address     = col_q;
    assign bus.row_address        = row_q;
    assign bus.row_address_active = row_active_q;
    assign bus.clk_pixel_load     = pixel_load;
    assign bus.clk_pixel          = pixel;
    assign bus.row_latch          = latch;
    assign bus.output_enable      = oe;
    assign bus.brightness_mask    = mask_q;
    assign bus.frame_start        = fstart;
    assign bus.busy               = (state_q != StIdle);
endmodule

// File: tb/tb_matrix_scan_bcm.sv
// Bench for matrix_scan_bcm: every cycle the DUT outputs are compared with a
// timeline model that derives strobes from the cycle offset within each (row, plane) period.
module tb_matrix_scan_bcm;
    localparam int COLUMNS   = 4;
    localparam int ROWS      = 2;
    localparam int BITPLANES = 2;
    localparam int BASE_ON   = 4;
    localparam int DIM_BITS  = 8;
    localparam int COL_W     = $clog2(COLUMNS);
    localparam int ROW_W     = $clog2(ROWS);
    localparam int OBS_W     = 6 + COL_W + 2 * ROW_W + BITPLANES;
    localparam int SHIFT_LEN = 2 * COLUMNS;

    logic clk_in = 1'b0;
    logic reset;

    matrix_scan_bcm_if #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .BITPLANES(BITPLANES), .DIM_BITS(DIM_BITS)
    ) bus ();

    matrix_scan_bcm #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .BITPLANES(BITPLANES), .BASE_ON(BASE_ON),
        .DIM_BITS(DIM_BITS)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_fs     = -1;
    int fs_gap      = 0;

    // Model: running flag, position (row, plane, offset t within the period), latched values.
    bit m_busy;
    int m_row, m_plane, m_t, m_dim, m_act, m_mask;

    function automatic int period(input int plane);
        return SHIFT_LEN + 2 + (BASE_ON << plane);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_row = 0; m_plane = 0; m_t = 0; m_dim = 0; m_act = 0; m_mask = 0;
    endtask

    task automatic model_advance(input bit en, input int dm);
        if (!m_busy) begin
            if (en) begin
                m_busy = 1; m_row = 0; m_plane = 0; m_t = 0;
            end
        end else begin
            if (m_t == 0 && m_row == 0 && m_plane == 0) m_dim = dm;
            if (m_t == SHIFT_LEN + 1) begin
                m_act  = m_row;
                m_mask = 1 << m_plane;
            end
            if (m_t == period(m_plane) - 1) begin
                m_t = 0;
                if (!en) m_busy = 0;
                else if (m_plane < BITPLANES - 1) m_plane++;
                else begin
                    m_plane = 0;
                    m_row   = (m_row + 1) % ROWS;
                end
            end else begin
                m_t++;
            end
        end
    endtask

    function automatic logic [OBS_W-1:0] model_outputs();
        logic [COL_W-1:0] col;
        logic load, pix, lat, oe, fs;
        int w, on;
        col = '0; load = 0; pix = 0; lat = 0; oe = 0; fs = 0;
        if (m_busy) begin
            if (m_t < SHIFT_LEN) begin
                col  = COL_W'(m_t / 2);
                load = (m_t % 2 == 0);
                pix  = (m_t % 2 == 1);
                fs   = (m_t == 0 && m_row == 0 && m_plane == 0);
            end else if (m_t == SHIFT_LEN + 1) begin
                lat = 1;
            end else if (m_t >= SHIFT_LEN + 2) begin
                w  = BASE_ON << m_plane;
                on = (w * (m_dim + 1)) >> DIM_BITS;
                oe = (m_t - (SHIFT_LEN + 2)) < on;
            end
        end
        return {m_busy, fs, load, pix, lat, oe, col, ROW_W'(m_row), ROW_W'(m_act),
                BITPLANES'(m_mask)};
    endfunction

    task automatic check(input string tag);
        logic [OBS_W-1:0] obs, exp_v;
        obs = {bus.busy, bus.frame_start, bus.clk_pixel_load, bus.clk_pixel, bus.row_latch,
               bus.output_enable, bus.column_address, bus.row_address, bus.row_address_active,
               bus.brightness_mask};
        exp_v = model_outputs();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: cycle %0d observed %b expected %b", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock: compare outputs, then advance the model with the inputs seen at the edge.
    task automatic step(input string tag);
        bit en;
        int dm;
        cyc++;
        if (bus.frame_start === 1'b1) begin
            if (last_fs >= 0) fs_gap = cyc - last_fs;
            last_fs = cyc;
        end
        check(tag);
        en = bus.enable;
        dm = int'(bus.dim);
        @(posedge clk_in);
        if (!reset) model_reset();
        else model_advance(en, dm);
        #1;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.dim    = '0;
        model_reset();
        #1;
        run("reset", 3);

        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.dim    = 8'd255;
        run("dim255", 130);
        check_int("frame_period_dim255", fs_gap, 64);

        bus.dim = 8'd127;
        run("dim127", 128);
        check_int("frame_period_dim127", fs_gap, 64);

        bus.dim = 8'd0;
        run("dim0", 128);
        check_int("frame_period_dim0", fs_gap, 64);

        bus.dim = 8'd200;
        for (int i = 0; i < 200; i++) begin
            if (m_busy && m_row == 1 && m_plane == 0 && m_t == 3) break;
            step("seek_row1");
        end
        bus.enable = 1'b0;
        run("stop", 16);
        check_int("stop_busy", int'(bus.busy), 0);
        check_int("stop_oe", int'(bus.output_enable), 0);
        run("idle", 4);
        bus.enable = 1'b1;
        step("restart");
        check_int("restart_fs", int'(bus.frame_start), 1);
        run("restart_run", 70);

        bus.dim = 8'd255;
        for (int i = 0; i < 200; i++) begin
            if (m_busy && m_t >= SHIFT_LEN + 3) break;
            step("seek_display");
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_reset");
        check_int("async_reset_busy", int'(bus.busy), 0);
        run("in_reset", 3);
        reset = 1'b1;
        run("after_reset", 66);

        for (int i = 0; i < 800; i++) begin
            bus.enable = ($urandom_range(0, 15) != 0);
            bus.dim    = DIM_BITS'($urandom_range(0, 255));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
- Parametrised successor to the fixed 64x16, 6-plane matrix scan generator.
- Drives column/row addressing, pixel-shift strobes, row latch and output enable for a HUB75-style panel.
- Uses binary-coded modulation: each bitplane's display window is weighted by its bit weight.
- Adds global dimming, run/stop control and a frame-start pulse; sits between the framebuffer reader (consumes column_address/clk_pixel_load) and the panel pads.

Parameters:
COLUMNS, 64, pixels shifted per row (>=2)
ROWS, 16, scan rows (row address lines = $clog2(ROWS))
BITPLANES, 6, brightness bits per colour
BASE_ON, 4, display cycles for bitplane 0; plane p window = BASE_ON<<p
DIM_BITS, 8, width of global dimming input

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
enable  input  1  run request; 0 = stop after current plane completes
dim  input  DIM_BITS  global brightness, sampled at frame start
column_address  output  $clog2(COLUMNS)  column being fetched/shifted
row_address  output  $clog2(ROWS)  row whose data is being shifted
row_address_active  output  $clog2(ROWS)  row currently driven to panel address lines
clk_pixel_load  output  1  one-cycle fetch strobe for column_address
clk_pixel  output  1  panel shift clock pulse
row_latch  output  1  one-cycle latch pulse
output_enable  output  1  1 = LEDs lit (pad inversion done outside this block)
brightness_mask  output  BITPLANES  one-hot current bitplane
frame_start  output  1  one-cycle pulse on entering row 0, plane 0 SHIFT
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0): every output 0; state IDLE; internal row/plane/column counters 0; dim_latched 0.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
- IDLE:
  - output_enable=0.
  - If enable=1, go to SHIFT next cycle with row=0, plane=0, and pulse frame_start.
- SHIFT: 2 cycles per column, 2*COLUMNS cycles total.
  - Phase A: clk_pixel_load=1, column_address=c.
  - Phase B: clk_pixel=1.
  - c counts 0..COLUMNS-1; after phase B of the last column, go to BLANK.
  - frame_start is also asserted on the first SHIFT cycle of row 0, plane 0.
  - dim_latched<=dim on that same cycle, so dim is constant for the whole frame.
- BLANK: 1 cycle, output_enable=0. Then LATCH.
- LATCH: 1 cycle.
  - row_latch=1.
  - row_address_active<=row_address.
  - brightness_mask<=1<<plane.
  - Then DISPLAY.
- DISPLAY: window W = BASE_ON<<plane cycles.
  - on_count = (W*(dim_latched+1))>>DIM_BITS.
  - output_enable=1 for the first on_count cycles of the window, 0 for the rest.
  - The window length is always W, so frame rate is independent of dim.
- End of DISPLAY:
  - plane<BITPLANES-1: plane+1, go to SHIFT (same row).
  - Otherwise plane=0; row wraps ROWS-1 -> 0, else row+1.
  - If enable=0 at the last DISPLAY cycle: go to IDLE and hold counters. Resuming restarts at row 0, plane 0 with frame_start.
  - Otherwise go to SHIFT.
- enable is sampled only in IDLE and at the end of DISPLAY; deasserting mid-plane never truncates a plane.
- Row timing: row_address changes only on entry to SHIFT. row_address_active changes only in LATCH.
- brightness_mask holds between LATCH pulses; it is 0 only after reset.
- Outside its strobe states, clk_pixel, clk_pixel_load and row_latch are 0.
- Period per (row, plane): 2*COLUMNS + 2 + (BASE_ON<<plane) cycles.
- Frame period: ROWS*(BITPLANES*(2*COLUMNS+2) + BASE_ON*(2^BITPLANES-1)) cycles.
- Counter widths: the display counter is sized for BASE_ON<<(BITPLANES-1) without overflow. The W*(dim+1) product is computed at full width before the shift.
- Reset asserted mid-operation forces all outputs to 0 immediately (asynchronous). Restart is from IDLE.

Test Plan (COLUMNS=4, ROWS=2, BITPLANES=2, BASE_ON=4 unless noted):
- Reset pulse low then high, enable=1, dim=255:
  - frame_start at first cycle after IDLE.
  - clk_pixel_load/clk_pixel alternate 8 cycles, column_address 0,0,1,1,2,2,3,3.
  - Then BLANK 1, row_latch 1, output_enable high 4 cycles.
  - Plane 1 window: output_enable high 8 cycles.
  - frame_start repeats every 64 cycles.
- dim=127: output_enable high 2 of 4 cycles (plane 0) and 4 of 8 (plane 1); total frame stays 64 cycles.
- dim=0: output_enable never high (on_count 0 for W=4 and W=8); strobes and latches unchanged.
- Row wrap:
  - row_address_active sequence 0,0,1,1,0 across successive latches.
  - brightness_mask sequence 01,10,01,10.
  - row_address leads row_address_active by one SHIFT phase.
- enable dropped mid-SHIFT of row 1, plane 0:
  - Plane completes with full display window, then IDLE, busy=0, output_enable=0.
  - Re-enable restarts at row 0 with frame_start.
- reset asserted mid-DISPLAY: all outputs 0 in the same cycle; after release with enable=1, the sequence matches the first scenario exactly.
